// File: rtl/aes_core_sched_if.sv
// Client/datapath/response bundle around the shared AES round scheduler.
// slave = scheduler side, master = requesters, round datapath and consumer.
interface aes_core_sched_if #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0][127:0] req_pt;
   logic [NREQ-1:0][127:0] req_key;
   logic                   core_load;
   logic                   core_en;
   logic [3:0]             core_round;
   logic [127:0]           core_pt;
   logic [127:0]           core_key;
   logic [127:0]           core_ct;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [127:0]           rsp_ct;
   logic                   busy;

   modport slave (
      input  req_valid, req_pt, req_key, core_ct, rsp_ready,
      output req_ready, core_load, core_en, core_round, core_pt, core_key,
             rsp_valid, rsp_id, rsp_ct, busy
   );

   modport master (
      output req_valid, req_pt, req_key, core_ct, rsp_ready,
      input  req_ready, core_load, core_en, core_round, core_pt, core_key,
             rsp_valid, rsp_id, rsp_ct, busy
   );
endinterface

// File: rtl/aes_core_sched.sv
// Round-robin scheduler sharing one multicycle AES-128 round datapath
// between NREQ requesters; sequences key add + ROUNDS rounds, returns tagged ct.
module aes_core_sched #(
   parameter int NREQ   = 2,
   parameter int ROUNDS = 10,
   parameter int IDW    = $clog2(NREQ)
) (
   input logic             clk,
   input logic             rst_n,
   aes_core_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ROUND, RESP} state_e;

   state_e         state_q, state_d;
   logic [3:0]     rnd_q, rnd_d;
   logic [IDW-1:0] last_q, last_d;
   logic [IDW-1:0] id_q, id_d;

   logic           any_req;
   logic [IDW-1:0] gnt_id;
   logic [IDW-1:0] cand;
   logic           grant_ok;
   logic [NREQ-1:0] ready;
   logic           load, en;
   logic [3:0]     round;
   logic [127:0]   pt, key;

   // Search starts one past the last winner and wraps, so the first hit is fair.
   always_comb begin
      any_req = 1'b0;
      gnt_id  = '0;
      cand    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(last_q) + k) % NREQ);
         if (!any_req && bus.req_valid[cand]) begin
            any_req = 1'b1;
            gnt_id  = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rnd_d    = rnd_q;
      last_d   = last_q;
      id_d     = id_q;
      grant_ok = 1'b0;
      ready    = '0;
      load     = 1'b0;
      en       = 1'b0;
      round    = 4'd0;
      pt       = '0;
      key      = '0;
      case (state_q)
         IDLE:  grant_ok = 1'b1;
         ROUND: begin
            en    = 1'b1;
            round = rnd_q;
            if (rnd_q == 4'(ROUNDS)) state_d = RESP;
            else                     rnd_d   = rnd_q + 4'd1;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               grant_ok = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A grant in RESP overlaps the response handshake, keeping the core busy back-to-back.
      if (grant_ok && any_req) begin
         ready[gnt_id] = 1'b1;
         load          = 1'b1;
         pt            = bus.req_pt[gnt_id];
         key           = bus.req_key[gnt_id];
         id_d          = gnt_id;
         last_d        = gnt_id;
         rnd_d         = 4'd1;
         state_d       = ROUND;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rnd_q   <= 4'd0;
         last_q  <= IDW'(NREQ - 1);
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         last_q  <= last_d;
         id_q    <= id_d;
      end
   end

   assign bus.req_ready  = ready;
   assign bus.core_load  = load;
   assign bus.core_en    = en;
   assign bus.core_round = round;
   assign bus.core_pt    = pt;
   assign bus.core_key   = key;
   assign bus.rsp_valid  = (state_q == RESP);
   assign bus.rsp_id     = id_q;
   assign bus.rsp_ct     = (state_q == RESP) ? bus.core_ct : '0;
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_aes_core_sched.sv
// Directed bench: FIPS-197 vector through a behavioural round datapath,
// round-robin order, backpressure, mid-operation reset, NREQ=3 ordering.
module tb_aes_core_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_core_sched_if #(.NREQ(2)) ifa ();
   aes_core_sched_if #(.NREQ(3)) ifb ();

   aes_core_sched #(.NREQ(2), .ROUNDS(10)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   aes_core_sched #(.NREQ(3), .ROUNDS(10)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT1      = 128'hdeadbeef_01234567_89abcdef_cafef00d;
   localparam logic [127:0] KEY1     = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---- behavioural AES-128 round datapath ----
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = xt(a);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] v = 8'h01;
      if (x == 8'h00) v = 8'h00;
      else for (int i = 0; i < 254; i++) v = gmul(v, x);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
         4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
         4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
         4'd10: return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = k;
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input bit last);
      logic [7:0] b[16];
      logic [7:0] t[16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
         a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
         if (!last) begin
            t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
      return o ^ rk;
   endfunction

   logic [127:0] dp_st = '0;
   logic [127:0] dp_rk = '0;
   logic [127:0] dp_nk;
   always @(posedge clk) begin
      if (ifa.core_load) begin
         dp_st <= ifa.core_pt ^ ifa.core_key;
         dp_rk <= ifa.core_key;
      end else if (ifa.core_en) begin
         dp_nk = next_key(dp_rk, rcon(ifa.core_round));
         dp_st <= aes_round(dp_st, dp_nk, ifa.core_round == 4'd10);
         dp_rk <= dp_nk;
      end
   end
   assign ifa.core_ct = dp_st;
   assign ifb.core_ct = '0;

   // ---- stimulus helpers ----
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_gnt_a(output int at);
      bit hit = 1'b0;
      at = -1;
      for (int i = 0; i < 20 && !hit; i++) begin
         tick(); #1;
         if (ifa.req_ready != '0) begin hit = 1'b1; at = cyc; end
      end
      if (!hit) chk("gnt_timeout_a", 128'd0, 128'd1);
   endtask

   task automatic wait_gnt_b(output int at);
      bit hit = 1'b0;
      at = -1;
      for (int i = 0; i < 20 && !hit; i++) begin
         tick(); #1;
         if (ifb.req_ready != '0) begin hit = 1'b1; at = cyc; end
      end
      if (!hit) chk("gnt_timeout_b", 128'd0, 128'd1);
   endtask

   initial begin
      int t0, g, at, prev, prev_id, exp_id, seen;
      logic [127:0] ct_hold;
      ifa.req_valid = '0; ifa.req_pt = '0; ifa.req_key = '0; ifa.rsp_ready = 1'b0;
      ifb.req_valid = '0; ifb.req_pt = '0; ifb.req_key = '0; ifb.rsp_ready = 1'b0;

      // reset state
      repeat (2) tick();
      #1;
      chk("rst_req_ready", 128'(ifa.req_ready), 128'd0);
      chk("rst_core_load", 128'(ifa.core_load), 128'd0);
      chk("rst_core_en",   128'(ifa.core_en), 128'd0);
      chk("rst_core_round",128'(ifa.core_round), 128'd0);
      chk("rst_core_pt",   ifa.core_pt, 128'd0);
      chk("rst_core_key",  ifa.core_key, 128'd0);
      chk("rst_rsp_valid", 128'(ifa.rsp_valid), 128'd0);
      chk("rst_rsp_ct",    ifa.rsp_ct, 128'd0);
      chk("rst_busy",      128'(ifa.busy), 128'd0);
      chk("rst_rsp_id",    128'(ifa.rsp_id), 128'd0);
      tick(); rst_n = 1'b1;

      // FIPS-197 single request on requester 0
      tick();
      ifa.req_pt[0] = FIPS_PT; ifa.req_key[0] = FIPS_KEY; ifa.req_valid = 2'b01;
      #1;
      chk("fips_grant",      128'(ifa.req_ready), 128'd1);
      chk("fips_load",       128'(ifa.core_load), 128'd1);
      chk("fips_round0",     128'(ifa.core_round), 128'd0);
      chk("fips_core_pt",    ifa.core_pt, FIPS_PT);
      chk("fips_core_key",   ifa.core_key, FIPS_KEY);
      t0 = cyc;
      for (int r = 1; r <= 10; r++) begin
         tick();
         if (r == 1) ifa.req_valid = 2'b00;
         #1;
         chk("round_en",    128'(ifa.core_en), 128'd1);
         chk("round_idx",   128'(ifa.core_round), 128'(r));
         chk("round_noload",128'(ifa.core_load), 128'd0);
         chk("round_nordy", 128'(ifa.req_ready), 128'd0);
      end
      tick(); #1;
      chk("fips_rsp_valid", 128'(ifa.rsp_valid), 128'd1);
      chk("fips_latency",   128'(cyc - t0), 128'd11);
      chk("fips_rsp_id",    128'(ifa.rsp_id), 128'd0);
      chk("fips_rsp_ct",    ifa.rsp_ct, FIPS_CT);
      chk("fips_busy",      128'(ifa.busy), 128'd1);
      ct_hold = ifa.rsp_ct;

      // backpressure with requester 1 waiting
      ifa.req_pt[1] = PT1; ifa.req_key[1] = KEY1; ifa.req_valid = 2'b10;
      #1;
      chk("bp_nordy0", 128'(ifa.req_ready), 128'd0);
      for (int i = 0; i < 5; i++) begin
         tick(); #1;
         chk("bp_valid", 128'(ifa.rsp_valid), 128'd1);
         chk("bp_id",    128'(ifa.rsp_id), 128'd0);
         chk("bp_ct",    ifa.rsp_ct, ct_hold);
         chk("bp_nordy", 128'(ifa.req_ready), 128'd0);
         chk("bp_noen",  128'(ifa.core_en), 128'd0);
      end
      tick(); ifa.rsp_ready = 1'b1;
      #1;
      chk("bp_same_cycle_gnt", 128'(ifa.req_ready), 128'd2);
      chk("bp_gnt_load",       128'(ifa.core_load), 128'd1);
      chk("bp_gnt_pt",         ifa.core_pt, PT1);
      chk("bp_gnt_key",        ifa.core_key, KEY1);
      g = cyc;

      // both requesters held valid: 0,1,0,1,0 spaced 11 cycles
      ifa.req_valid = 2'b11;
      prev = g; prev_id = 1;
      for (int k = 0; k < 5; k++) begin
         exp_id = (k % 2 == 0) ? 0 : 1;
         wait_gnt_a(at);
         chk("rr_grant",   128'(ifa.req_ready), 128'(1 << exp_id));
         chk("rr_spacing", 128'(at - prev), 128'd11);
         chk("rr_rsp_id",  128'(ifa.rsp_id), 128'(prev_id));
         chk("rr_rsp_vld", 128'(ifa.rsp_valid), 128'd1);
         prev = at; prev_id = exp_id;
      end

      // reset while core_round == 5
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         tick(); #1;
         if (ifa.core_round == 4'd5) seen = 1;
      end
      chk("mid_round5", 128'(ifa.core_round), 128'd5);
      rst_n = 1'b0; ifa.req_valid = 2'b00;
      #1;
      chk("mid_rst_busy",  128'(ifa.busy), 128'd0);
      chk("mid_rst_en",    128'(ifa.core_en), 128'd0);
      chk("mid_rst_round", 128'(ifa.core_round), 128'd0);
      chk("mid_rst_rsp",   128'(ifa.rsp_valid), 128'd0);
      chk("mid_rst_ct",    ifa.rsp_ct, 128'd0);
      tick(); #1;
      chk("mid_rst_hold",  128'(ifa.busy), 128'd0);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick(); #1;
         if (ifa.rsp_valid || ifa.busy) seen++;
      end
      chk("no_rsp_after_rst", 128'(seen), 128'd0);
      tick(); ifa.req_valid = 2'b11;
      #1;
      chk("tie_after_rst", 128'(ifa.req_ready), 128'd1);

      // requester 1 pulses valid during ROUND, then withdraws
      tick(); ifa.req_valid = 2'b10; ifa.rsp_ready = 1'b0;
      #1;
      chk("wd_nordy1", 128'(ifa.req_ready), 128'd0);
      tick(); #1;
      chk("wd_nordy2", 128'(ifa.req_ready), 128'd0);
      tick(); ifa.req_valid = 2'b00;
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         #1;
         if (ifa.rsp_valid) seen = 1;
         else tick();
      end
      chk("wd_rsp_valid", 128'(ifa.rsp_valid), 128'd1);
      ifa.rsp_ready = 1'b1;
      #1;
      chk("wd_no_gnt", 128'(ifa.req_ready), 128'd0);
      tick(); #1;
      chk("wd_idle_busy", 128'(ifa.busy), 128'd0);
      chk("wd_idle_rsp",  128'(ifa.rsp_valid), 128'd0);
      chk("wd_idle_load", 128'(ifa.core_load), 128'd0);

      // NREQ=3, all valid: 0,1,2,0
      tick();
      ifb.rsp_ready = 1'b1; ifb.req_valid = 3'b111;
      #1;
      chk("n3_gnt0", 128'(ifb.req_ready), 128'd1);
      wait_gnt_b(at);
      chk("n3_gnt1", 128'(ifb.req_ready), 128'd2);
      wait_gnt_b(at);
      chk("n3_gnt2", 128'(ifb.req_ready), 128'd4);
      wait_gnt_b(at);
      chk("n3_gnt3", 128'(ifb.req_ready), 128'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
